// File: rtl/sap_ram_pkg.sv
// Shared types and default sizes for the SAP program/data RAM.
// Optional feature macro used by this block: SAP_RAM_INV_OUT_EN.
package sap_ram_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } sap_ram_state_t;

  localparam int SAP_RAM_DATA_W = 8;
  localparam int SAP_RAM_ADDR_W = 4;

endpackage : sap_ram_pkg

// File: rtl/sap_ram_array.sv
// Bare DEPTH x DATA_W storage: one synchronous write port, one combinational
// read port. Contents are deliberately not reset; the top clears them.
module sap_ram_array #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Store one word per cycle when the write port is enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule : sap_ram_array

// File: rtl/sap_ram_sync.sv
// Single-port synchronous RAM for the SAP datapath: clocked write, registered
// read with a one-cycle valid strobe, and a power-on clear sequencer.
// Macro SAP_RAM_INV_OUT_EN: when defined, reads return inverted data and the
// output register resets to all ones ('189-compatible); storage is always true data.
module sap_ram_sync
  import sap_ram_pkg::*;
#(
  parameter int DATA_W     = SAP_RAM_DATA_W,
  parameter int ADDR_W     = SAP_RAM_ADDR_W,
  parameter int INIT_CLEAR = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic              we_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              rd_valid,
  output logic              busy,
  output logic              req_drop
);

  localparam logic [ADDR_W-1:0] LAST_PTR = {ADDR_W{1'b1}};
  localparam sap_ram_state_t RST_STATE = (INIT_CLEAR != 0) ? ST_CLEAR : ST_IDLE;
`ifdef SAP_RAM_INV_OUT_EN
  localparam logic [DATA_W-1:0] DOUT_RST = {DATA_W{1'b1}};
`else
  localparam logic [DATA_W-1:0] DOUT_RST = {DATA_W{1'b0}};
`endif

  sap_ram_state_t    state_q,    state_d;
  logic [ADDR_W-1:0] clr_ptr_q,  clr_ptr_d;
  logic [DATA_W-1:0] dout_q,     dout_d;
  logic              rd_valid_q, rd_valid_d;
  logic              req_drop_q, req_drop_d;

  logic              arr_we_s;
  logic [ADDR_W-1:0] arr_waddr_s;
  logic [DATA_W-1:0] arr_wdata_s;
  logic [DATA_W-1:0] arr_rdata_s;
  logic [DATA_W-1:0] rd_word_s;

  sap_ram_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we_s),
    .waddr (arr_waddr_s),
    .wdata (arr_wdata_s),
    .raddr (addr),
    .rdata (arr_rdata_s)
  );

`ifdef SAP_RAM_INV_OUT_EN
  assign rd_word_s = ~arr_rdata_s;
`else
  assign rd_word_s = arr_rdata_s;
`endif

  // Next-state logic: clear sequencer owns the write port while busy,
  // otherwise accept one user read or write per cycle.
  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    dout_d      = dout_q;
    rd_valid_d  = 1'b0;
    req_drop_d  = 1'b0;
    arr_we_s    = 1'b0;
    arr_waddr_s = addr;
    arr_wdata_s = din;
    case (state_q)
      ST_CLEAR: begin
        arr_we_s    = 1'b1;
        arr_waddr_s = clr_ptr_q;
        arr_wdata_s = {DATA_W{1'b0}};
        req_drop_d  = ~cs_n;
        if (clr_ptr_q == LAST_PTR) begin
          state_d   = ST_IDLE;
          clr_ptr_d = {ADDR_W{1'b0}};
        end else begin
          state_d   = ST_CLEAR;
          clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        end
      end
      ST_IDLE: begin
        if (!cs_n) begin
          if (!we_n) begin
            arr_we_s = 1'b1;
          end else begin
            dout_d     = rd_word_s;
            rd_valid_d = 1'b1;
          end
        end else begin
          arr_we_s = 1'b0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        clr_ptr_d = {ADDR_W{1'b0}};
      end
    endcase
  end

  // State, clear pointer and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RST_STATE;
      clr_ptr_q  <= {ADDR_W{1'b0}};
      dout_q     <= DOUT_RST;
      rd_valid_q <= 1'b0;
      req_drop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      dout_q     <= dout_d;
      rd_valid_q <= rd_valid_d;
      req_drop_q <= req_drop_d;
    end
  end

  assign dout     = dout_q;
  assign rd_valid = rd_valid_q;
  assign req_drop = req_drop_q;
  assign busy     = (state_q == ST_CLEAR);

endmodule : sap_ram_sync

// File: tb/tb_sap_ram_sync.sv
// Directed self-checking bench for sap_ram_sync: one instance with the power-on
// clear enabled, one with it disabled. Honours SAP_RAM_INV_OUT_EN.
module tb_sap_ram_sync;

  logic       clk;
  logic       rst;
  logic       cs_n, we_n;
  logic [3:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       rd_valid, busy, req_drop;

  logic       nc_cs_n, nc_we_n;
  logic [3:0] nc_addr;
  logic [7:0] nc_din;
  logic [7:0] nc_dout;
  logic       nc_rd_valid, nc_busy, nc_req_drop;

  int total = 0;
  int bad   = 0;

`ifdef SAP_RAM_INV_OUT_EN
  localparam logic [7:0] DOUT_RST = 8'hFF;
`else
  localparam logic [7:0] DOUT_RST = 8'h00;
`endif

  sap_ram_sync #(.DATA_W(8), .ADDR_W(4), .INIT_CLEAR(1)) u_dut (
    .clk(clk), .rst(rst), .cs_n(cs_n), .we_n(we_n), .addr(addr), .din(din),
    .dout(dout), .rd_valid(rd_valid), .busy(busy), .req_drop(req_drop)
  );

  sap_ram_sync #(.DATA_W(8), .ADDR_W(4), .INIT_CLEAR(0)) u_dut_nc (
    .clk(clk), .rst(rst), .cs_n(nc_cs_n), .we_n(nc_we_n), .addr(nc_addr), .din(nc_din),
    .dout(nc_dout), .rd_valid(nc_rd_valid), .busy(nc_busy), .req_drop(nc_req_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected read-back of a stored word as seen on dout.
  function automatic logic [7:0] xf(input logic [7:0] d);
`ifdef SAP_RAM_INV_OUT_EN
    return ~d;
`else
    return d;
`endif
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    cs_n = 1'b0; we_n = 1'b0; addr = a; din = d;
    tick();
    cs_n = 1'b1; we_n = 1'b1;
    check_eq("wr_no_valid", {31'd0, rd_valid}, 32'd0);
  endtask

  task automatic do_read(input string tag, input logic [3:0] a, input logic [7:0] d);
    cs_n = 1'b0; we_n = 1'b1; addr = a;
    tick();
    cs_n = 1'b1;
    check_eq(tag, {24'd0, dout}, {24'd0, xf(d)});
    check_eq("rd_valid", {31'd0, rd_valid}, 32'd1);
  endtask

  initial begin
    int cnt;
    rst = 1'b1; cs_n = 1'b1; we_n = 1'b1; addr = 4'd0; din = 8'd0;
    nc_cs_n = 1'b1; nc_we_n = 1'b1; nc_addr = 4'd0; nc_din = 8'd0;
    repeat (3) tick();

    // reset state
    check_eq("rst_busy",     {31'd0, busy},     32'd1);
    check_eq("rst_dout",     {24'd0, dout},     {24'd0, DOUT_RST});
    check_eq("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check_eq("rst_req_drop", {31'd0, req_drop}, 32'd0);
    check_eq("nc_rst_busy",  {31'd0, nc_busy},  32'd0);

    // clear sequence: 16 busy cycles, a dropped write to addr 5 at clear cycle 4
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (k == 4) begin
        cs_n = 1'b0; we_n = 1'b0; addr = 4'd5; din = 8'h77;
      end
      tick();
      cs_n = 1'b1; we_n = 1'b1;
      check_eq("clr_busy", {31'd0, busy}, (k < 16) ? 32'd1 : 32'd0);
      check_eq("clr_req_drop", {31'd0, req_drop}, (k == 4) ? 32'd1 : 32'd0);
      if (k == 1) check_eq("nc_busy_after_rst", {31'd0, nc_busy}, 32'd0);
      if (k == 4) check_eq("drop_dout_hold", {24'd0, dout}, {24'd0, DOUT_RST});
    end

    // every word reads back cleared, one access per cycle
    for (int a = 0; a < 16; a++) begin
      do_read("clr_rd", 4'(a), 8'h00);
    end
    tick();
    check_eq("idle_rd_valid", {31'd0, rd_valid}, 32'd0);
    do_read("drop_rd5", 4'd5, 8'h00);

    // write then read the same address next cycle
    do_write(4'd3, 8'hA5);
    do_read("rd_after_wr", 4'd3, 8'hA5);
    tick();
    check_eq("pulse_len", {31'd0, rd_valid}, 32'd0);
    check_eq("dout_hold", {24'd0, dout}, {24'd0, xf(8'hA5)});

    // alternate write/read over all addresses with idle gaps
    for (int a = 0; a < 16; a++) begin
      do_write(4'(a), 8'(a) ^ 8'h3C);
      do_read("alt_rd", 4'(a), 8'(a) ^ 8'h3C);
      for (int g = 0; g < 2; g++) begin
        tick();
        check_eq("gap_rd_valid", {31'd0, rd_valid}, 32'd0);
        check_eq("gap_dout", {24'd0, dout}, {24'd0, xf(8'(a) ^ 8'h3C)});
      end
    end

    // reset reasserted mid-clear restarts the full 16-cycle clear
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) tick();
    check_eq("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    check_eq("rerst_busy", {31'd0, busy}, 32'd1);
    check_eq("rerst_dout", {24'd0, dout}, {24'd0, DOUT_RST});
    rst = 1'b0;
    cnt = 0;
    while (busy && cnt < 40) begin
      tick();
      cnt++;
    end
    check_eq("restart_len", cnt, 32'd16);
    for (int a = 0; a < 16; a++) begin
      do_read("reclr_rd", 4'(a), 8'h00);
    end

    // no-clear instance: immediate access
    check_eq("nc_busy", {31'd0, nc_busy}, 32'd0);
    nc_cs_n = 1'b0; nc_we_n = 1'b0; nc_addr = 4'd15; nc_din = 8'h11;
    tick();
    nc_we_n = 1'b1;
    check_eq("nc_wr_valid", {31'd0, nc_rd_valid}, 32'd0);
    tick();
    nc_cs_n = 1'b1;
    check_eq("nc_rd", {24'd0, nc_dout}, {24'd0, xf(8'h11)});
    check_eq("nc_rd_valid", {31'd0, nc_rd_valid}, 32'd1);
    check_eq("nc_req_drop", {31'd0, nc_req_drop}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sap_ram_sync
